// File: rtl/sram_pkg.sv
// Shared types and helpers for the simple-dual-port SRAM block.
package sram_pkg;

  typedef enum logic {CLEAR, READY} sram_state_t;

  function automatic int unsigned depth_of(input int unsigned addr_bits);
    return 32'd1 << addr_bits;
  endfunction

endpackage

// File: rtl/sram_array.sv
// Storage with one write and one registered read port; write-first on address collision.
// Read data/valid appear one cycle after the request; no backpressure, every request is served.
module sram_array
  import sram_pkg::*;
#(
  parameter int N         = 8,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [N-1:0]         wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [N-1:0]         rdata_o,
  output logic                 rvld_o
);

  localparam int unsigned DEPTH = depth_of(ADDR_BITS);

  logic [N-1:0] mem [DEPTH];
  logic [N-1:0] rdata_d, rdata_q;
  logic         rvld_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // A same-address write in this cycle wins over the stored word.
  always_comb begin
    rdata_d = rdata_q;
    if (re_i) begin
      rdata_d = (we_i && (waddr_i == raddr_i)) ? wdata_i : mem[raddr_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
      rvld_q  <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rvld_q  <= re_i;
    end
  end

  assign rdata_o = rdata_q;
  assign rvld_o  = rvld_q;

endmodule

// File: rtl/sram_dual_port.sv
// Simple-dual-port SRAM that zeroes every word after reset before raising SRAM_ready.
// Read latency 1 cycle; requests arriving before SRAM_ready are dropped, not queued.
module sram_dual_port
  import sram_pkg::*;
#(
  parameter int N         = 8,
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SRAM_writeEnable,
  input  logic [ADDR_BITS-1:0] SRAM_write_address,
  input  logic [N-1:0]         SRAM_data_in,
  input  logic                 SRAM_readEnable,
  input  logic [ADDR_BITS-1:0] SRAM_read_address,
  output logic [N-1:0]         SRAM_data,
  output logic                 SRAM_data_valid,
  output logic                 SRAM_ready
);

  localparam int unsigned DEPTH = depth_of(ADDR_BITS);
  localparam logic [ADDR_BITS:0] LAST = (ADDR_BITS+1)'(DEPTH - 1);

  sram_state_t          state_d, state_q;
  logic [ADDR_BITS:0]   cnt_d, cnt_q;
  logic                 arr_we, arr_re;
  logic [ADDR_BITS-1:0] arr_waddr;
  logic [N-1:0]         arr_wdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    arr_we    = 1'b0;
    arr_re    = 1'b0;
    arr_waddr = SRAM_write_address;
    arr_wdata = SRAM_data_in;
    unique case (state_q)
      CLEAR: begin
        arr_we    = 1'b1;
        arr_waddr = cnt_q[ADDR_BITS-1:0];
        arr_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = READY;
      end
      READY: begin
        arr_we = SRAM_writeEnable;
        arr_re = SRAM_readEnable;
      end
    endcase
    // A reset edge must not disturb memory or produce a read.
    if (rst) begin
      arr_we = 1'b0;
      arr_re = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  sram_array #(
    .N         (N),
    .ADDR_BITS (ADDR_BITS)
  ) u_array (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (arr_we),
    .waddr_i (arr_waddr),
    .wdata_i (arr_wdata),
    .re_i    (arr_re),
    .raddr_i (SRAM_read_address),
    .rdata_o (SRAM_data),
    .rvld_o  (SRAM_data_valid)
  );

  assign SRAM_ready = (state_q == READY);

endmodule

// File: tb/tb_sram_dual_port.sv
// Bench for sram_dual_port (N=8, ADDR_BITS=3): directed steps plus random traffic against a memory model.
module tb_sram_dual_port;

  localparam int N = 8;
  localparam int AB = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic [AB-1:0] wa = '0;
  logic [N-1:0]  wd = '0;
  logic          re = 1'b0;
  logic [AB-1:0] ra = '0;
  logic [N-1:0]  dout;
  logic          dvld;
  logic          rdy;

  sram_dual_port #(.N(N), .ADDR_BITS(AB)) dut (
    .clk                (clk),
    .rst                (rst),
    .SRAM_writeEnable   (we),
    .SRAM_write_address (wa),
    .SRAM_data_in       (wd),
    .SRAM_readEnable    (re),
    .SRAM_read_address  (ra),
    .SRAM_data          (dout),
    .SRAM_data_valid    (dvld),
    .SRAM_ready         (rdy)
  );

  always #5 clk = ~clk;

  logic [N-1:0] model [DEPTH];
  logic [N-1:0] exp_data = '0;
  logic         exp_vld = 1'b0;
  logic         exp_rdy = 1'b0;
  int           clr_left = DEPTH;
  int           nerr = 0;
  int           nchk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: predict from the model, drive, step past the edge, compare.
  task automatic cyc(input logic r, input logic w, input logic [AB-1:0] a_w,
                     input logic [N-1:0] d_w, input logic rd, input logic [AB-1:0] a_r);
    if (r) begin
      clr_left = DEPTH;
      exp_rdy  = 1'b0;
      exp_vld  = 1'b0;
      exp_data = '0;
    end else if (clr_left > 0) begin
      clr_left--;
      exp_vld = 1'b0;
      if (clr_left == 0) begin
        exp_rdy = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
      end
    end else begin
      exp_vld = rd;
      if (rd) exp_data = (w && a_w == a_r) ? d_w : model[a_r];
      if (w) model[a_w] = d_w;
    end
    rst = r; we = w; wa = a_w; wd = d_w; re = rd; ra = a_r;
    @(posedge clk);
    #1;
    chk("ready", 32'(rdy), 32'(exp_rdy));
    chk("valid", 32'(dvld), 32'(exp_vld));
    chk("data", 32'(dout), 32'(exp_data));
  endtask

  int rdy_edge;

  initial begin
    // Reset, then clear with junk requests that must be ignored (write 0xFF @0 at cycle 2).
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= DEPTH; k++) begin
      if (k == 2) cyc(0, 1, 3'd0, 8'hFF, 1, 3'd0);
      else cyc(0, 1'($urandom), 3'($urandom), 8'($urandom), 1'($urandom), 3'($urandom));
    end
    chk("ready_after_clear", 32'(rdy), 32'd1);

    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 1, 3'(i));
    chk("read7_zero", 32'(dout), 32'h00);

    // Write then read next cycle; neighbour untouched.
    cyc(0, 1, 3'd3, 8'hA5, 0, 0);
    cyc(0, 0, 0, 0, 1, 3'd3);
    chk("rd3_a5", 32'(dout), 32'hA5);
    cyc(0, 0, 0, 0, 1, 3'd4);
    chk("rd4_zero", 32'(dout), 32'h00);
    cyc(0, 0, 0, 0, 0, 0);
    chk("hold_data", 32'(dout), 32'h00);

    // Collision returns the new data.
    cyc(0, 1, 3'd5, 8'h3C, 1, 3'd5);
    chk("collide_3c", 32'(dout), 32'h3C);

    // Random traffic with frequent collisions.
    for (int k = 0; k < 200; k++) begin
      logic [AB-1:0] a1, a2;
      a1 = 3'($urandom);
      a2 = ($urandom_range(0, 3) == 0) ? a1 : 3'($urandom);
      cyc(0, 1'($urandom), a1, 8'($urandom), 1'($urandom), a2);
    end

    // Fill with 0x11, reset, reset again mid-clear, then time the clear.
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 3'(i), 8'h11, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 4; k++) cyc(0, 1, 3'(k), 8'hEE, 1, 3'(k));
    cyc(1, 0, 0, 0, 0, 0);
    rdy_edge = 0;
    for (int k = 1; k <= DEPTH + 2; k++) begin
      cyc(0, 0, 0, 0, 0, 0);
      if (rdy && rdy_edge == 0) rdy_edge = k;
    end
    chk("ready_edge", 32'(rdy_edge), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 0, 0, 0, 1, 3'(i));
      chk("cleared_word", 32'(dout), 32'h00);
    end

    // Streaming reads of value i+1 at address i.
    for (int i = 0; i < DEPTH; i++) cyc(0, 1, 3'(i), 8'(i + 1), 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      cyc(0, 0, 0, 0, 1, 3'(i));
      chk("stream_vld", 32'(dvld), 32'd1);
      chk("stream_data", 32'(dout), 32'(i + 1));
    end
    cyc(0, 0, 0, 0, 0, 0);
    chk("vld_drop", 32'(dvld), 32'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
